pipeline_hazard_sequencer: RTL and testbench
============================================

# pipeline_hazard_sequencer

Central stall/flush sequencer for the 5-stage RV32 pipeline. Combines the existing load-use detection, EX-stage taken-branch flushes, and the data-memory request/grant/response handshake for the instruction in MEM. Drives PC, pipeline-register write-enable, bubble and flush controls. Sits beside the pipeline registers in the core top, between the datapath and the data memory port.

## Interface
Parameters:
- `MEM_TIMEOUT`, 64: max cycles waiting in REQ or RESP before abort (≥2).
- `CNT_W`, 32: performance counter width.

Ports:
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `if_id_rs1`, `if_id_rs2` input 5: source registers of the instruction in ID.
- `id_ex_rd` input 5: destination of the instruction in EX.
- `id_ex_mem_read` input 1: instruction in EX is a load.
- `branch_taken_ex` input 1: branch/jump in EX resolved taken.
- `mem_access` input 1: instruction in MEM is a load or store (level).
- `mem_is_store` input 1: qualifies `mem_access`; 1 = store.
- `dmem_gnt` input 1: memory accepted the request.
- `dmem_rvalid` input 1: load data valid.
- `dmem_req` output 1: memory request.
- `pc_write`, `if_id_write`, `id_ex_write`, `ex_mem_write` output 1: register enables.
- `id_ex_bubble` output 1: zero control into ID/EX.
- `if_id_flush`, `id_ex_flush` output 1: squash register contents.
- `mem_wb_bubble` output 1: insert NOP into MEM/WB.
- `mem_err` output 1: sticky timeout flag.
- `cnt_load_use`, `cnt_flush`, `cnt_mem_wait` output CNT_W: performance counters (present only with macro).

## Operation
- FSM states: RUN, REQ, RESP. Reset state RUN.
- `done` (combinational): store & `dmem_gnt` in RUN/REQ; load & `dmem_rvalid` in RESP; 1 on timeout abort.
- RUN: `dmem_req` = `mem_access`. No access → stay. Store + gnt → stay, `done`. Load + gnt → RESP. No gnt → REQ.
- REQ: `dmem_req`=1. Gnt: store → RUN with `done`; load → RESP.
- RESP: `dmem_req`=0. `dmem_rvalid` → RUN with `done`.
- `freeze` = `mem_access` & !`done`. While freeze: all four `*_write`=0, `mem_wb_bubble`=1, flushes and `id_ex_bubble` = 0. Branch and load-use are deferred, not lost (EX/ID held).
- Priority when not frozen: branch flush > load-use.
- Branch: `if_id_flush`=`id_ex_flush`=1, `pc_write`=1; load-use suppressed.
- Load-use: `id_ex_mem_read` & `id_ex_rd`≠0 & (`id_ex_rd`==rs1 | ==rs2) → `pc_write`=`if_id_write`=0, `id_ex_bubble`=1, `id_ex_write`=1.
- Timeout: wait counter clears on entering REQ/RESP and increments each cycle there. On reaching MEM_TIMEOUT−1: `mem_err` set (sticky until reset), FSM → RUN, `done`=1 that cycle.
- Default outputs (RUN, no events): all writes 1, bubbles/flushes 0, `dmem_req`=0.

## Timing
- Load-use, branch and freeze outputs are combinational from inputs and state. Stall/flush takes effect at the next edge.
- Zero-wait store (gnt in same cycle): no freeze. Load with same-cycle gnt and next-cycle rvalid: 1 freeze cycle.
- Load-use stall is exactly 1 cycle. It repeats only if the condition persists.
- Reset (async, any state): FSM→RUN, wait counter 0, `mem_err`=0, counters 0. `dmem_req` drops immediately. Outputs take default values given inputs.
- `dmem_gnt`/`dmem_rvalid` are ignored in states where they are not expected.

## Configuration
- `HAZARD_PERF_CNT_EN` defined: the three counters exist. Each saturates at all-ones.
  - `cnt_load_use` +1 per load-use stall cycle.
  - `cnt_flush` +1 per branch flush.
  - `cnt_mem_wait` +1 per freeze cycle.
- Undefined: counter ports and logic are absent. All other behaviour is identical.

## Structure
- `hazard_pkg`: state enum (RUN, REQ, RESP) and default MEM_TIMEOUT constant.
- Instantiates the existing `hazard_detection` module for the load-use compare.
- The sequencer gates that module's outputs with freeze and branch priority.

## Test plan
- Load-use: rd=rs1=5'b10101, `id_ex_mem_read`=1 → `pc_write`=0, `if_id_write`=0, `id_ex_bubble`=1 for one cycle. Same with rd=0 → no stall.
- Branch and load-use same cycle: `branch_taken_ex`=1 with load-use match → both flushes=1, `pc_write`=1, `id_ex_bubble`=0.
- Load, gnt delayed 3 cycles, rvalid 2 cycles later:
  - REQ×3, then RESP×2.
  - Freeze for 5 cycles; `dmem_req` high for exactly the 3 REQ cycles plus the gnt cycle.
- Store with same-cycle gnt → no freeze, state stays RUN.
- Timeout (MEM_TIMEOUT=4), gnt never asserted → `mem_err`=1 after 4 cycles in REQ, return to RUN, freeze released.
- Async reset asserted mid-RESP → state RUN, `dmem_req`=0, counters 0 (with `HAZARD_PERF_CNT_EN`).

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int DEFAULT_MEM_TIMEOUT = 64;

endpackage

// File: rtl/hazard_detection.sv
// Load-use compare: the load in EX writes a register the instruction in ID reads.
module hazard_detection (
  input  logic [4:0] if_id_rs1,
  input  logic [4:0] if_id_rs2,
  input  logic [4:0] id_ex_rd,
  input  logic       id_ex_mem_read,
  output logic       load_use
);

  assign load_use = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                    ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// Stall/flush sequencer: load-use, EX branch flush and data-memory handshake freeze.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_sequencer
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_mem_read,
  input  logic             branch_taken_ex,
  input  logic             mem_access,
  input  logic             mem_is_store,
  input  logic             dmem_gnt,
  input  logic             dmem_rvalid,
  output logic             dmem_req,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_bubble,
  output logic             mem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_load_use,
  output logic [CNT_W-1:0] cnt_flush,
  output logic [CNT_W-1:0] cnt_mem_wait
`endif
);

  localparam int                WAIT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
  logic              done;
  logic              abort;
  logic              freeze;
  logic              load_use;
  logic              lu_stall;
  logic              flush_evt;

  hazard_detection u_hazard_detection (
    .if_id_rs1      (if_id_rs1),
    .if_id_rs2      (if_id_rs2),
    .id_ex_rd       (id_ex_rd),
    .id_ex_mem_read (id_ex_mem_read),
    .load_use       (load_use)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  // A response beats a timeout landing in the same cycle.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    done     = 1'b0;
    abort    = 1'b0;
    dmem_req = 1'b0;
    case (state_q)
      ST_RUN: begin
        dmem_req = mem_access;
        if (mem_access) begin
          wait_d = '0;
          if (!dmem_gnt)         state_d = ST_REQ;
          else if (mem_is_store) done    = 1'b1;
          else                   state_d = ST_RESP;
        end
      end
      ST_REQ: begin
        dmem_req = 1'b1;
        if (dmem_gnt) begin
          wait_d = '0;
          if (mem_is_store) begin
            done    = 1'b1;
            state_d = ST_RUN;
          end else begin
            state_d = ST_RESP;
          end
        end else if (wait_q == WAIT_LAST) begin
          abort   = 1'b1;
          done    = 1'b1;
          state_d = ST_RUN;
        end else begin
          wait_d = wait_q + WAIT_ONE;
        end
      end
      ST_RESP: begin
        if (dmem_rvalid) begin
          done    = 1'b1;
          state_d = ST_RUN;
        end else if (wait_q == WAIT_LAST) begin
          abort   = 1'b1;
          done    = 1'b1;
          state_d = ST_RUN;
        end else begin
          wait_d = wait_q + WAIT_ONE;
        end
      end
      default: state_d = ST_RUN;
    endcase
    err_d = err_q | abort;
  end

  assign freeze    = mem_access && !done;
  assign flush_evt = !freeze && branch_taken_ex;
  assign lu_stall  = !freeze && !branch_taken_ex && load_use;
  assign mem_err   = err_q;

  // Freeze holds every stage, so a pending branch or load-use simply re-presents next cycle.
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    ex_mem_write  = 1'b1;
    id_ex_bubble  = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    if (freeze) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (flush_evt) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (lu_stall) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_lu_q, cnt_lu_d;
  logic [CNT_W-1:0] cnt_fl_q, cnt_fl_d;
  logic [CNT_W-1:0] cnt_mw_q, cnt_mw_d;

  always_comb begin
    cnt_lu_d = cnt_lu_q;
    cnt_fl_d = cnt_fl_q;
    cnt_mw_d = cnt_mw_q;
    if (lu_stall  && !(&cnt_lu_q)) cnt_lu_d = cnt_lu_q + CNT_ONE;
    if (flush_evt && !(&cnt_fl_q)) cnt_fl_d = cnt_fl_q + CNT_ONE;
    if (freeze    && !(&cnt_mw_q)) cnt_mw_d = cnt_mw_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_lu_q <= '0;
      cnt_fl_q <= '0;
      cnt_mw_q <= '0;
    end else begin
      cnt_lu_q <= cnt_lu_d;
      cnt_fl_q <= cnt_fl_d;
      cnt_mw_q <= cnt_mw_d;
    end
  end

  assign cnt_load_use = cnt_lu_q;
  assign cnt_flush    = cnt_fl_q;
  assign cnt_mem_wait = cnt_mw_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Self-checking bench: transaction-level model compared every cycle, plus literal scenario checks.
module tb_pipeline_hazard_sequencer;

  localparam int T  = 4;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    if_id_rs1, if_id_rs2, id_ex_rd;
  logic          id_ex_mem_read, branch_taken_ex, mem_access, mem_is_store;
  logic          dmem_gnt, dmem_rvalid;
  logic          dmem_req, pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic          id_ex_bubble, if_id_flush, id_ex_flush, mem_wb_bubble, mem_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [CW-1:0] cnt_load_use, cnt_flush, cnt_mem_wait;
`endif

  always #5 clk = ~clk;

  pipeline_hazard_sequencer #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .if_id_rs1       (if_id_rs1),
    .if_id_rs2       (if_id_rs2),
    .id_ex_rd        (id_ex_rd),
    .id_ex_mem_read  (id_ex_mem_read),
    .branch_taken_ex (branch_taken_ex),
    .mem_access      (mem_access),
    .mem_is_store    (mem_is_store),
    .dmem_gnt        (dmem_gnt),
    .dmem_rvalid     (dmem_rvalid),
    .dmem_req        (dmem_req),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .id_ex_write     (id_ex_write),
    .ex_mem_write    (ex_mem_write),
    .id_ex_bubble    (id_ex_bubble),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .mem_wb_bubble   (mem_wb_bubble),
    .mem_err         (mem_err)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .cnt_load_use    (cnt_load_use),
    .cnt_flush       (cnt_flush),
    .cnt_mem_wait    (cnt_mem_wait)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a memory access is either waiting to be accepted, waiting
  // for load data, or not outstanding; waited counts cycles spent waiting.
  bit          m_await_gnt, m_await_data, m_err;
  int          m_waited;
  logic [CW-1:0] m_lu, m_fl, m_mw;

  function automatic bit m_timed_out();
    if (m_await_data) return !dmem_rvalid && (m_waited >= T - 1);
    if (m_await_gnt)  return !dmem_gnt && (m_waited >= T - 1);
    return 1'b0;
  endfunction

  function automatic bit m_done();
    if (m_await_data) return dmem_rvalid || m_timed_out();
    if (m_await_gnt)  return (dmem_gnt && mem_is_store) || m_timed_out();
    return mem_access && dmem_gnt && mem_is_store;
  endfunction

  function automatic bit m_freeze();
    return mem_access && !m_done();
  endfunction

  function automatic bit m_hazard();
    return id_ex_mem_read && (id_ex_rd != 0) && (id_ex_rd == if_id_rs1 || id_ex_rd == if_id_rs2);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_await_gnt  <= 1'b0;
      m_await_data <= 1'b0;
      m_err        <= 1'b0;
      m_waited     <= 0;
      m_lu         <= '0;
      m_fl         <= '0;
      m_mw         <= '0;
    end else begin
      if (m_freeze() && m_mw != '1) m_mw <= m_mw + 1;
      if (!m_freeze() && branch_taken_ex && m_fl != '1) m_fl <= m_fl + 1;
      if (!m_freeze() && !branch_taken_ex && m_hazard() && m_lu != '1) m_lu <= m_lu + 1;
      if (m_timed_out()) m_err <= 1'b1;
      if (m_await_data || m_await_gnt) begin
        if (m_done()) begin
          m_await_gnt  <= 1'b0;
          m_await_data <= 1'b0;
        end else if (m_await_gnt && dmem_gnt) begin
          m_await_gnt  <= 1'b0;
          m_await_data <= 1'b1;
          m_waited     <= 0;
        end else begin
          m_waited <= m_waited + 1;
        end
      end else if (mem_access && !m_done()) begin
        m_await_gnt  <= !dmem_gnt;
        m_await_data <= dmem_gnt;
        m_waited     <= 0;
      end
    end
  end

  always @(negedge clk) begin
    bit fz, br, lu;
    fz = m_freeze();
    br = !fz && branch_taken_ex;
    lu = !fz && !branch_taken_ex && m_hazard();
    check("dmem_req", dmem_req, m_await_gnt ? 1'b1 : (m_await_data ? 1'b0 : mem_access));
    check("pc_write", pc_write, !fz && !lu);
    check("if_id_write", if_id_write, !fz && !lu);
    check("id_ex_write", id_ex_write, !fz);
    check("ex_mem_write", ex_mem_write, !fz);
    check("id_ex_bubble", id_ex_bubble, lu);
    check("if_id_flush", if_id_flush, br);
    check("id_ex_flush", id_ex_flush, br);
    check("mem_wb_bubble", mem_wb_bubble, fz);
    check("mem_err", mem_err, m_err);
`ifdef HAZARD_PERF_CNT_EN
    check("cnt_load_use", cnt_load_use, m_lu);
    check("cnt_flush", cnt_flush, m_fl);
    check("cnt_mem_wait", cnt_mem_wait, m_mw);
`endif
  end

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic mr, input logic br, input logic acc, input logic st,
                       input logic gnt, input logic rv);
    @(posedge clk);
    #1;
    if_id_rs1 = rs1; if_id_rs2 = rs2; id_ex_rd = rd; id_ex_mem_read = mr;
    branch_taken_ex = br; mem_access = acc; mem_is_store = st;
    dmem_gnt = gnt; dmem_rvalid = rv;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_frz, n_req;
    if_id_rs1 = 0; if_id_rs2 = 0; id_ex_rd = 0; id_ex_mem_read = 0; branch_taken_ex = 0;
    mem_access = 0; mem_is_store = 0; dmem_gnt = 0; dmem_rvalid = 0;
    repeat (2) @(negedge clk);
    check("lit_rst_pc_write", pc_write, 1);
    check("lit_rst_dmem_req", dmem_req, 0);
    check("lit_rst_mem_err", mem_err, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    $display("reset released");

    drive(5'b10101, 5'd0, 5'b10101, 1, 0, 0, 0, 0, 0);
    check("lit_lu_pc_write", pc_write, 0);
    check("lit_lu_if_id_write", if_id_write, 0);
    check("lit_lu_bubble", id_ex_bubble, 1);
    check("lit_lu_id_ex_write", id_ex_write, 1);
    drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
    check("lit_lu_once_pc_write", pc_write, 1);
    drive(5'd1, 5'd7, 5'd7, 1, 0, 0, 0, 0, 0);
    check("lit_lu_rs2_bubble", id_ex_bubble, 1);
    drive(5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0, 0);
    check("lit_lu_x0_pc_write", pc_write, 1);
    check("lit_lu_x0_bubble", id_ex_bubble, 0);
    $display("load-use vectors done");

    drive(5'b10101, 5'd0, 5'b10101, 1, 1, 0, 0, 0, 0);
    check("lit_br_if_id_flush", if_id_flush, 1);
    check("lit_br_id_ex_flush", id_ex_flush, 1);
    check("lit_br_pc_write", pc_write, 1);
    check("lit_br_bubble", id_ex_bubble, 0);
    $display("branch over load-use done");

    n_frz = 0; n_req = 0;
    for (int c = 0; c < 6; c++) begin
      drive(5'd3, 5'd0, 5'd3, c == 1, c == 1, 1, 0, c == 3 || c == 4, c == 1 || c == 5);
      if (!pc_write && mem_wb_bubble) n_frz++;
      if (dmem_req) n_req++;
    end
    check("lit_load_freeze_cycles", n_frz, 5);
    check("lit_load_req_cycles", n_req, 4);
    drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
    $display("delayed load done");

    drive(5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 1, 0);
    check("lit_store_pc_write", pc_write, 1);
    check("lit_store_mem_wb_bubble", mem_wb_bubble, 0);
    check("lit_store_req", dmem_req, 1);
    drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
    check("lit_store_stays_run", dmem_req, 0);
    $display("zero-wait store done");

    n_frz = 0;
    for (int c = 0; c < 2; c++) begin
      drive(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, c == 0, c == 1);
      if (!pc_write && mem_wb_bubble) n_frz++;
    end
    check("lit_fast_load_freeze", n_frz, 1);
    drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
    $display("fast load done");

    for (int c = 0; c < 5; c++) begin
      drive(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0);
      check("lit_to_pc_write", pc_write, c == 4);
      check("lit_to_err_pending", mem_err, 0);
    end
    drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
    check("lit_to_mem_err", mem_err, 1);
    check("lit_to_req_low", dmem_req, 0);
    drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
    check("lit_to_err_sticky", mem_err, 1);
    $display("timeout done");

    drive(5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    mem_access = 1'b0;
    #1;
    check("lit_arst_req", dmem_req, 0);
    check("lit_arst_mem_err", mem_err, 0);
    check("lit_arst_pc_write", pc_write, 1);
`ifdef HAZARD_PERF_CNT_EN
    check("lit_arst_cnt_lu", cnt_load_use, 0);
    check("lit_arst_cnt_fl", cnt_flush, 0);
    check("lit_arst_cnt_mw", cnt_mem_wait, 0);
`endif
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
    check("lit_post_rst_req", dmem_req, 0);
    drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
    $display("async reset mid-response done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
